operand_stage: RTL and testbench

Registered decode-to-execute operand stage, the parametrised successor of the decode operand mux. It takes one decoded instruction per cycle, builds both ALU operands plus a third operand (store data or jump base) from register-file data, immediates and PC. Read-after-write hazards are resolved with a per-register pending-write scoreboard instead of upstream bubble flags. The result sits in a valid/ready output register feeding execute.

---
 rtl/operand_stage_pkg.sv | 68 ++++++
 rtl/operand_stage_imm_gen.sv | 33 +++
 rtl/operand_stage.sv | 211 +++++++++++++++++++++
 tb/tb_operand_stage.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_stage_pkg.sv
// Shared types and helpers for the decode-to-execute operand stage.
// Provides the control word, the registered output payload and sub-word
// extension functions used when building operands and immediates.
package operand_stage_pkg;

    localparam int unsigned OPS_XLEN = 64;
    localparam int unsigned OPS_REGW = 5;

    typedef enum logic [3:0] {
        OP_ALU   = 4'd0,
        OP_ALUW  = 4'd1,
        OP_ALUI  = 4'd2,
        OP_ALUIW = 4'd3,
        OP_LD    = 4'd4,
        OP_SD    = 4'd5,
        OP_LUI   = 4'd6,
        OP_AUIPC = 4'd7,
        OP_JAL   = 4'd8,
        OP_JALR  = 4'd9,
        OP_BR    = 4'd10
    } op_e;

    typedef enum logic [3:0] {
        FN_ADD  = 4'd0,
        FN_SUB  = 4'd1,
        FN_SLL  = 4'd2,
        FN_SLT  = 4'd3,
        FN_SLTU = 4'd4,
        FN_XOR  = 4'd5,
        FN_SRL  = 4'd6,
        FN_SRA  = 4'd7,
        FN_OR   = 4'd8,
        FN_AND  = 4'd9,
        FN_MUL  = 4'd10,
        FN_DIV  = 4'd11,
        FN_DIVU = 4'd12,
        FN_REM  = 4'd13,
        FN_REMU = 4'd14
    } alufunc_e;

    typedef struct packed {
        op_e      op;
        alufunc_e alufunc;
    } contral_t;

    typedef struct packed {
        logic [OPS_XLEN-1:0] pc;
        contral_t            ctl;
        logic [OPS_REGW-1:0] rd;
        logic                wen;
        logic [OPS_XLEN-1:0] a;
        logic [OPS_XLEN-1:0] b;
        logic [OPS_XLEN-1:0] c;
    } opstage_out_t;

    function automatic logic [OPS_XLEN-1:0] sext12(input logic [11:0] v);
        return {{(OPS_XLEN-12){v[11]}}, v};
    endfunction

    function automatic logic [OPS_XLEN-1:0] sext32(input logic [31:0] v);
        return {{(OPS_XLEN-32){v[31]}}, v};
    endfunction

    function automatic logic [OPS_XLEN-1:0] zext32(input logic [31:0] v);
        return {{(OPS_XLEN-32){1'b0}}, v};
    endfunction

endpackage

// File: rtl/operand_stage_imm_gen.sv
// Immediate generator: decodes I/S/U immediates from the instruction word.
// Each immediate is driven only for the ops that consume it, zero otherwise.
// Ports: instr_i (instruction), op_i (decoded op),
//        immi_o / imms_o / immu_o (sign-extended I, S, U immediates).
module operand_stage_imm_gen
    import operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64
) (
    input  logic [31:0]     instr_i,
    input  op_e             op_i,
    output logic [XLEN-1:0] immi_o,
    output logic [XLEN-1:0] imms_o,
    output logic [XLEN-1:0] immu_o
);

    // Opcode field is decoded upstream; only the immediate bits matter here.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    always_comb begin
        immi_o = '0;
        imms_o = '0;
        immu_o = '0;
        case (op_i)
            OP_ALUI, OP_ALUIW, OP_LD: immi_o = XLEN'(sext12(instr_i[31:20]));
            OP_SD:                    imms_o = XLEN'(sext12({instr_i[31:25], instr_i[11:7]}));
            OP_LUI, OP_AUIPC:         immu_o = XLEN'(sext32({instr_i[31:12], 12'b0}));
            default: ;
        endcase
    end

endmodule

// File: rtl/operand_stage.sv
// Registered decode-to-execute operand stage with a per-register
// pending-write scoreboard for RAW hazard detection.
// Optional feature: define OPSTAGE_WB_FWD_EN to forward wb_data into a
// source whose only outstanding writer retires this cycle.
// Ports: clk/reset (sync, active-high); in_* decode handshake and fields;
//        rf_rd1/rf_rd2 register-file reads; wb_* writeback retire port;
//        flush kills the output entry; out_* registered execute payload;
//        stall_cnt counts hazard/saturation stall cycles.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int unsigned XLEN = 64,
    parameter int unsigned NREG = 32,
    parameter int unsigned CNTW = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         in_pc,
    input  logic [31:0]             in_instr,
    input  contral_t                in_ctl,
    input  logic [$clog2(NREG)-1:0] in_rs1,
    input  logic [$clog2(NREG)-1:0] in_rs2,
    input  logic [$clog2(NREG)-1:0] in_rd,
    input  logic                    in_wen,
    input  logic [XLEN-1:0]         rf_rd1,
    input  logic [XLEN-1:0]         rf_rd2,
    input  logic                    wb_valid,
    input  logic [$clog2(NREG)-1:0] wb_rd,
    input  logic [XLEN-1:0]         wb_data,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         out_pc,
    output contral_t                out_ctl,
    output logic [$clog2(NREG)-1:0] out_rd,
    output logic                    out_wen,
    output logic [XLEN-1:0]         out_a,
    output logic [XLEN-1:0]         out_b,
    output logic [XLEN-1:0]         out_c,
    output logic [31:0]             stall_cnt
);

    localparam int unsigned REGW = $clog2(NREG);

    logic [CNTW-1:0] pend_q [NREG];
    logic [CNTW-1:0] pend_d [NREG];
    opstage_out_t    out_q, out_d;
    logic            out_valid_q, out_valid_d;
    logic [31:0]     stall_q, stall_d;

    logic [XLEN-1:0] immi, imms, immu;
    logic            use1, use2, fwd1, fwd2, haz1, haz2, hazard, sat;
    logic            accept, flush_kill;
    logic [XLEN-1:0] rs1_val, rs2_val, a_c, b_c, c_c;

    operand_stage_imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (in_instr),
        .op_i    (in_ctl.op),
        .immi_o  (immi),
        .imms_o  (imms),
        .immu_o  (immu)
    );

    // Which register sources the op actually reads.
    always_comb begin
        use1 = 1'b1;
        use2 = 1'b1;
        case (in_ctl.op)
            OP_ALUI, OP_ALUIW, OP_LD, OP_JALR: use2 = 1'b0;
            OP_LUI, OP_AUIPC, OP_JAL: begin
                use1 = 1'b0;
                use2 = 1'b0;
            end
            default: ;
        endcase
    end

`ifdef OPSTAGE_WB_FWD_EN
    // Last outstanding writer retiring now: take its data instead of stalling.
    assign fwd1 = wb_valid && (wb_rd == in_rs1) && (pend_q[in_rs1] == CNTW'(1));
    assign fwd2 = wb_valid && (wb_rd == in_rs2) && (pend_q[in_rs2] == CNTW'(1));
`else
    logic unused_wb_data;
    assign unused_wb_data = ^wb_data;
    assign fwd1 = 1'b0;
    assign fwd2 = 1'b0;
`endif

    assign rs1_val = fwd1 ? wb_data : rf_rd1;
    assign rs2_val = fwd2 ? wb_data : rf_rd2;

    assign haz1   = use1 && (pend_q[in_rs1] != '0) && !fwd1;
    assign haz2   = use2 && (pend_q[in_rs2] != '0) && !fwd2;
    assign hazard = haz1 || haz2;
    assign sat    = in_wen && (in_rd != '0) && (pend_q[in_rd] == {CNTW{1'b1}});

    assign in_ready   = (!out_valid_q || out_ready) && !hazard && !sat && !flush;
    assign accept     = in_valid && in_ready;
    assign flush_kill = flush && out_valid_q && out_q.wen;

    // Operand selection per op class.
    always_comb begin
        a_c = rs1_val;
        b_c = rs2_val;
        c_c = '0;
        case (in_ctl.op)
            OP_ALUW: begin
                case (in_ctl.alufunc)
                    FN_DIV, FN_REM: begin
                        a_c = XLEN'(sext32(rs1_val[31:0]));
                        b_c = XLEN'(sext32(rs2_val[31:0]));
                    end
                    FN_DIVU, FN_REMU: begin
                        a_c = XLEN'(zext32(rs1_val[31:0]));
                        b_c = XLEN'(zext32(rs2_val[31:0]));
                    end
                    default: ;
                endcase
            end
            OP_ALUI, OP_ALUIW, OP_LD: b_c = immi;
            OP_SD: begin
                b_c = imms;
                c_c = rs2_val;
            end
            OP_LUI: begin
                a_c = '0;
                b_c = immu;
            end
            OP_AUIPC: begin
                a_c = in_pc;
                b_c = immu;
            end
            OP_JAL: begin
                a_c = in_pc;
                b_c = XLEN'(4);
            end
            OP_JALR: begin
                a_c = in_pc;
                b_c = XLEN'(4);
                c_c = rs1_val;
            end
            default: ;
        endcase
    end

    // Scoreboard: issue increments, writeback and flush-undo decrement.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            pend_d[r] = pend_q[r]
                      + CNTW'(accept && in_wen && (in_rd == REGW'(r)))
                      - CNTW'(wb_valid && (wb_rd == REGW'(r)))
                      - CNTW'(flush_kill && (out_q.rd == OPS_REGW'(r)));
        end
        pend_d[0] = '0;
    end

    // Output register and stall counter next state.
    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        stall_d     = stall_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_d.pc    = OPS_XLEN'(in_pc);
            out_d.ctl   = in_ctl;
            out_d.rd    = OPS_REGW'(in_rd);
            out_d.wen   = in_wen;
            out_d.a     = OPS_XLEN'(a_c);
            out_d.b     = OPS_XLEN'(b_c);
            out_d.c     = OPS_XLEN'(c_c);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        if (in_valid && !flush && (hazard || sat) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            stall_q     <= '0;
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            stall_q     <= stall_d;
            for (int r = 0; r < NREG; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_pc    = XLEN'(out_q.pc);
    assign out_ctl   = out_q.ctl;
    assign out_rd    = REGW'(out_q.rd);
    assign out_wen   = out_q.wen;
    assign out_a     = XLEN'(out_q.a);
    assign out_b     = XLEN'(out_q.b);
    assign out_c     = XLEN'(out_q.c);
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: directed instructions push expected
// payloads on accept; a monitor pops and compares on each output transfer.
module tb_operand_stage;
    import operand_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, in_wen, wb_valid, flush;
    logic        out_valid, out_ready, out_wen;
    logic [63:0] in_pc, rf_rd1, rf_rd2, wb_data, out_pc, out_a, out_b, out_c;
    logic [31:0] in_instr, stall_cnt;
    logic [4:0]  in_rs1, in_rs2, in_rd, wb_rd, out_rd;
    contral_t    in_ctl, out_ctl;

    typedef struct {
        logic [63:0] pc, a, b, c;
        logic [4:0]  rd;
        logic        wen;
    } exp_t;

    exp_t        exp_q[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          exp_stall = 0;
    logic [31:0] ins;

    always #5 clk = ~clk;

    operand_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_instr(in_instr), .in_ctl(in_ctl), .in_rs1(in_rs1),
        .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen), .rf_rd1(rf_rd1),
        .rf_rd2(rf_rd2), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_ctl(out_ctl), .out_rd(out_rd), .out_wen(out_wen),
        .out_a(out_a), .out_b(out_b), .out_c(out_c), .stall_cnt(stall_cnt)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input op_e op, input alufunc_e fn, input logic [63:0] pc,
                         input logic [31:0] instr, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic wen,
                         input logic [63:0] r1, input logic [63:0] r2);
        in_valid      = 1'b1;
        in_ctl.op     = op;
        in_ctl.alufunc = fn;
        in_pc         = pc;
        in_instr      = instr;
        in_rs1        = rs1;
        in_rs2        = rs2;
        in_rd         = rd;
        in_wen        = wen;
        rf_rd1        = r1;
        rf_rd2        = r2;
    endtask

    task automatic push(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        exp_t e;
        e.pc  = in_pc;
        e.a   = a;
        e.b   = b;
        e.c   = c;
        e.rd  = in_rd;
        e.wen = in_wen;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for in_ready, record the expectation, take the accept edge.
    task automatic send(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        int k = 0;
        @(negedge clk);
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck 0 for pc 0x%0h", in_pc);
        end else begin
            push(a, b, c);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_output: got pc 0x%0h expected none", out_pc);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_c", out_c, e.c);
                    chk("out_pc", out_pc, e.pc);
                    chk("out_rd", 64'(out_rd), 64'(e.rd));
                    chk("out_wen", 64'(out_wen), 64'(e.wen));
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pc = '0; in_instr = '0; in_ctl = '0;
        in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_wen = 1'b0; rf_rd1 = '0; rf_rd2 = '0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0; flush = 1'b0; out_ready = 1'b1;
        fork
            monitor();
        join_none
        tick();
        tick();
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_out_a", out_a, 64'd0);
        chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        tick();

        // ADDI x1,x0,-5 and latency check
        ins = {12'hFFB, 5'd0, 3'b000, 5'd1, 7'h13};
        drive(OP_ALUI, FN_ADD, 64'h8000_0000, ins, 5'd0, 5'd0, 5'd1, 1'b1, 64'd0, 64'd0);
        send(64'd0, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0);
        chk("addi_latency", 64'(out_valid), 64'd1);
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 64'h0;
        tick();
        wb_valid = 1'b0;

        // AUIPC with imm 0x80000
        ins = {20'h80000, 5'd2, 7'h17};
        drive(OP_AUIPC, FN_ADD, 64'h1000, ins, 5'd0, 5'd0, 5'd2, 1'b0, 64'd0, 64'd0);
        send(64'h1000, 64'hFFFF_FFFF_8000_0000, 64'd0);

        // ALUW divide extensions
        drive(OP_ALUW, FN_DIVU, 64'h1004, 32'd0, 5'd3, 5'd4, 5'd2, 1'b0,
              64'hFFFF_FFFF_8000_0000, 64'd3);
        send(64'h0000_0000_8000_0000, 64'd3, 64'd0);
        drive(OP_ALUW, FN_DIV, 64'h1008, 32'd0, 5'd3, 5'd4, 5'd2, 1'b0,
              64'hFFFF_FFFF_8000_0000, 64'd3);
        send(64'hFFFF_FFFF_8000_0000, 64'd3, 64'd0);
        drive(OP_ALUW, FN_REMU, 64'h100C, 32'd0, 5'd3, 5'd4, 5'd2, 1'b0,
              64'hAAAA_BBBB_0000_0010, 64'hFFFF_FFFF_FFFF_FFFF);
        send(64'h10, 64'h0000_0000_FFFF_FFFF, 64'd0);
        drive(OP_ALUW, FN_REM, 64'h1010, 32'd0, 5'd3, 5'd4, 5'd2, 1'b0,
              64'h1234_5678_0000_0010, 64'h0000_0000_8000_0001);
        send(64'h10, 64'hFFFF_FFFF_8000_0001, 64'd0);

        // SD, LUI, JAL, JALR
        ins = {7'h7F, 5'd11, 5'd10, 3'b011, 5'h18, 7'h23};
        drive(OP_SD, FN_ADD, 64'h1014, ins, 5'd10, 5'd11, 5'd0, 1'b0, 64'h1000, 64'hDEAD_BEEF);
        send(64'h1000, 64'hFFFF_FFFF_FFFF_FFF8, 64'hDEAD_BEEF);
        ins = {20'h12345, 5'd3, 7'h37};
        drive(OP_LUI, FN_ADD, 64'h2000, ins, 5'd8, 5'd4, 5'd3, 1'b0, 64'h77, 64'h88);
        send(64'd0, 64'h1234_5000, 64'd0);
        drive(OP_JAL, FN_ADD, 64'h3000, 32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 64'h77, 64'h88);
        send(64'h3000, 64'd4, 64'd0);
        drive(OP_JALR, FN_ADD, 64'h2000, 32'd0, 5'd12, 5'd0, 5'd0, 1'b0, 64'h4000, 64'h88);
        send(64'h2000, 64'd4, 64'h4000);

        // RAW stall on x5
        drive(OP_ALUI, FN_ADD, 64'h100, 32'd0, 5'd0, 5'd0, 5'd5, 1'b1, 64'd0, 64'd0);
        send(64'd0, 64'd0, 64'd0);
        drive(OP_ALU, FN_ADD, 64'h104, 32'd0, 5'd5, 5'd5, 5'd6, 1'b0, 64'h111, 64'h111);
        repeat (3) begin
            @(negedge clk);
            chk("raw_stall_ready", 64'(in_ready), 64'd0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 64'hABCD;
`ifdef OPSTAGE_WB_FWD_EN
        @(negedge clk);
        chk("raw_fwd_ready", 64'(in_ready), 64'd1);
        push(64'hABCD, 64'hABCD, 64'd0);
        tick();
        in_valid = 1'b0;
        wb_valid = 1'b0;
`else
        @(negedge clk);
        chk("raw_wb_cycle_ready", 64'(in_ready), 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        rf_rd1 = 64'hABCD;
        rf_rd2 = 64'hABCD;
        @(negedge clk);
        chk("raw_after_wb_ready", 64'(in_ready), 64'd1);
        push(64'hABCD, 64'hABCD, 64'd0);
        tick();
        in_valid = 1'b0;
`endif
        chk("raw_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

        // Saturation: three writers to x7, fourth stalls until a retire
        repeat (3) begin
            drive(OP_ALUI, FN_ADD, 64'h200, 32'd0, 5'd0, 5'd0, 5'd7, 1'b1, 64'd0, 64'd0);
            send(64'd0, 64'd0, 64'd0);
        end
        drive(OP_ALUI, FN_ADD, 64'h204, 32'd0, 5'd0, 5'd0, 5'd7, 1'b1, 64'd0, 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("sat_stall_ready", 64'(in_ready), 64'd0);
            tick();
            exp_stall++;
        end
        wb_valid = 1'b1; wb_rd = 5'd7;
        @(negedge clk);
        chk("sat_wb_cycle_ready", 64'(in_ready), 64'd0);
        tick();
        exp_stall++;
        wb_valid = 1'b0;
        @(negedge clk);
        chk("sat_release_ready", 64'(in_ready), 64'd1);
        push(64'd0, 64'd0, 64'd0);
        tick();
        in_valid = 1'b0;
        chk("sat_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        tick();

        // Flush of a pending x9 writer
        out_ready = 1'b0;
        drive(OP_ALUI, FN_ADD, 64'h300, 32'd0, 5'd0, 5'd0, 5'd9, 1'b1, 64'd0, 64'd0);
        @(negedge clk);
        chk("flush_setup_ready", 64'(in_ready), 64'd1);
        tick();
        chk("flush_setup_valid", 64'(out_valid), 64'd1);
        drive(OP_ALU, FN_ADD, 64'h304, 32'd0, 5'd9, 5'd9, 5'd10, 1'b0, 64'h99, 64'h99);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_accept", 64'(in_ready), 64'd0);
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("flush_kills_valid", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("flush_pend_undone", 64'(in_ready), 64'd1);
        push(64'h99, 64'h99, 64'd0);
        tick();
        in_valid = 1'b0;
        chk("flush_stall_cnt", 64'(stall_cnt), 64'(exp_stall));
        tick();

        // Backpressure, with a hazard-stalled consumer of x7 behind it
        out_ready = 1'b0;
        drive(OP_ALU, FN_ADD, 64'h400, 32'd0, 5'd13, 5'd14, 5'd0, 1'b0, 64'h55, 64'h66);
        send(64'h55, 64'h66, 64'd0);
        drive(OP_ALU, FN_ADD, 64'h404, 32'd0, 5'd7, 5'd7, 5'd8, 1'b0, 64'd1, 64'd1);
        repeat (4) begin
            @(negedge clk);
            chk("bp_ready", 64'(in_ready), 64'd0);
            chk("bp_out_a", out_a, 64'h55);
            chk("bp_out_pc", out_pc, 64'h400);
            tick();
            exp_stall++;
        end
        chk("bp_stall_cnt", 64'(stall_cnt), 64'(exp_stall));

        // Reset mid-stall clears outputs, counter and scoreboard
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        exp_stall = 0;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_a", out_a, 64'd0);
        chk("rst_out_b", out_b, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_pend_cleared", 64'(in_ready), 64'd1);
        push(64'd1, 64'd1, 64'd0);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("rst_stall_after", 64'(stall_cnt), 64'(exp_stall));
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
